// File: rtl/harq_send_packer.sv
// harq_send_packer
// Collects ping/pong SRAM read data that follows the send FSM's read
// addresses by one cycle. Each word is tagged with its source and an
// end-of-burst marker, then queued in a FIFO. The FIFO head drives a
// valid/ready stream.
// Optional feature macro: HARQ_SEND_PARITY_EN adds 10 bits of per-16-bit-lane
// even parity to each entry and drives them on o_parity.

module harq_send_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter int AFULL_LVL  = 12
) (
   input  logic         i_core_clk,
   input  logic         i_rx_rst,
   input  logic         i_ping_busy,
   input  logic         i_pong_busy,
   input  logic [159:0] i_ping_rd_data,
   input  logic [159:0] i_pong_rd_data,
   output logic [159:0] o_tdata,
   output logic         o_tvalid,
   input  logic         i_tready,
   output logic         o_tlast,
   output logic         o_tsrc,
   output logic         o_afull,
   output logic         o_overflow,
`ifdef HARQ_SEND_PARITY_EN
   output logic [9:0]   o_parity,
`endif
   output logic         o_sel_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef HARQ_SEND_PARITY_EN
   localparam int EW = 172;
`else
   localparam int EW = 162;
`endif
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

   logic          ping_busy_d;
   logic          pong_busy_d;
   logic          armed;
   logic          sel_err;
   logic          overflow;
   logic          cap_valid;
   logic          cap_src;
   logic          cap_last;
   logic [159:0]  cap_data;
   logic [EW-1:0] cap_entry;
   logic [EW-1:0] head;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   // Delay the busy flags to line up with the SRAM read data. Capture stays
   // disarmed after reset until both busy lines are seen low, so a burst cut
   // by reset is never picked up halfway.
   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         ping_busy_d <= 1'b0;
         pong_busy_d <= 1'b0;
         armed       <= 1'b0;
      end else begin
         ping_busy_d <= i_ping_busy & armed;
         pong_busy_d <= i_pong_busy & armed;
         armed       <= armed | ~(i_ping_busy | i_pong_busy);
      end
   end

   // Select the captured word. Ping wins a collision. The last flag is set
   // when the chosen busy line has just dropped.
   always_comb begin
      cap_valid = ping_busy_d | pong_busy_d;
      cap_src   = ~ping_busy_d;
      cap_data  = ping_busy_d ? i_ping_rd_data : i_pong_rd_data;
      cap_last  = ping_busy_d ? ~i_ping_busy : ~i_pong_busy;
   end

`ifdef HARQ_SEND_PARITY_EN
   logic [9:0] cap_par;

   // Per-lane even parity of the captured word, stored next to the data.
   always_comb begin
      cap_par = '0;
      for (int k = 0; k < 10; k++) begin
         cap_par[k] = ^cap_data[16*k +: 16];
      end
   end

   assign cap_entry = {cap_par, cap_src, cap_last, cap_data};
   assign o_parity  = empty ? 10'd0 : head[171:162];
`else
   assign cap_entry = {cap_src, cap_last, cap_data};
`endif

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == DEPTH_CNT);
   assign pop   = ~empty & i_tready;
   assign push  = cap_valid & (~full | pop);
   assign drop  = cap_valid & full & ~pop;

   // FIFO storage. It has no reset, because the pointers alone decide which
   // entries are live.
   always_ff @(posedge i_core_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= cap_entry;
      end
   end

   // The pointers carry one extra wrap bit to tell full from empty. The sticky
   // flags clear only on reset.
   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         sel_err  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (i_ping_busy & i_pong_busy) begin
            sel_err <= 1'b1;
         end
      end
   end

   assign head       = mem[rd_ptr[AW-1:0]];
   assign o_tvalid   = ~empty;
   assign o_tdata    = empty ? 160'd0 : head[159:0];
   assign o_tlast    = ~empty & head[160];
   assign o_tsrc     = ~empty & head[161];
   assign o_afull    = (count >= AFULL_CNT);
   assign o_overflow = overflow;
   assign o_sel_err  = sel_err;

endmodule

// File: tb/tb_harq_send_packer.sv
// tb_harq_send_packer
// Directed bench for harq_send_packer with hand-computed expected values.
// A negedge monitor logs every accepted word as {src, last, data}. Define
// HARQ_SEND_PARITY_EN to exercise the parity output as well.

module tb_harq_send_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_ping_busy;
   logic         i_pong_busy;
   logic [159:0] i_ping_rd_data;
   logic [159:0] i_pong_rd_data;
   logic [159:0] o_tdata;
   logic         o_tvalid;
   logic         i_tready;
   logic         o_tlast;
   logic         o_tsrc;
   logic         o_afull;
   logic         o_overflow;
   logic         o_sel_err;
`ifdef HARQ_SEND_PARITY_EN
   logic [9:0]   o_parity;
`endif

   int compared   = 0;
   int mismatched = 0;
   logic [161:0] mon_q[$];

   harq_send_packer #(.FIFO_DEPTH(16), .AFULL_LVL(12)) dut (
      .i_core_clk     (clk),
      .i_rx_rst       (rst),
      .i_ping_busy    (i_ping_busy),
      .i_pong_busy    (i_pong_busy),
      .i_ping_rd_data (i_ping_rd_data),
      .i_pong_rd_data (i_pong_rd_data),
      .o_tdata        (o_tdata),
      .o_tvalid       (o_tvalid),
      .i_tready       (i_tready),
      .o_tlast        (o_tlast),
      .o_tsrc         (o_tsrc),
      .o_afull        (o_afull),
      .o_overflow     (o_overflow),
`ifdef HARQ_SEND_PARITY_EN
      .o_parity       (o_parity),
`endif
      .o_sel_err      (o_sel_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Log every word the consumer accepts, sampled away from the active edge
   always @(negedge clk) begin
      if (!rst && o_tvalid && i_tready) begin
         mon_q.push_back({o_tsrc, o_tlast, o_tdata});
      end
   end

   // Safety net so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of busy flags and read data, then advance one clock
   task automatic applyStimulus(input logic pi, input logic po, input logic [159:0] pd, input logic [159:0] qd);
      i_ping_busy    = pi;
      i_pong_busy    = po;
      i_ping_rd_data = pd;
      i_pong_rd_data = qd;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 160'd0, 160'd0);
   endtask

   task automatic checkWord(input string tag, input int idx, input logic [159:0] d, input logic s, input logic l);
      logic [161:0] w;
      w = '1;
      if (idx < mon_q.size()) begin
         w = mon_q[idx];
      end
      checkOutput({tag, "_data"}, w[159:0], d);
      checkOutput({tag, "_src"}, 160'(w[161]), 160'(s));
      checkOutput({tag, "_last"}, 160'(w[160]), 160'(l));
   endtask

   initial begin
      rst            = 1'b1;
      i_ping_busy    = 1'b0;
      i_pong_busy    = 1'b0;
      i_ping_rd_data = '0;
      i_pong_rd_data = '0;
      i_tready       = 1'b1;
      repeat (3) tick();

      // Everything reads as zero while reset is held
      checkOutput("rst_tvalid", 160'(o_tvalid), 160'd0);
      checkOutput("rst_tdata", o_tdata, 160'd0);
      checkOutput("rst_tlast", 160'(o_tlast), 160'd0);
      checkOutput("rst_tsrc", 160'(o_tsrc), 160'd0);
      checkOutput("rst_afull", 160'(o_afull), 160'd0);
      checkOutput("rst_overflow", 160'(o_overflow), 160'd0);
      checkOutput("rst_sel_err", 160'(o_sel_err), 160'd0);
      rst = 1'b0;
      idle(3);
      mon_q.delete();

      // Ping burst of four words; first valid two cycles after busy rises
      applyStimulus(1'b1, 1'b0, 160'd0, 160'd0);
      checkOutput("t1_lat0", 160'(o_tvalid), 160'd0);
      applyStimulus(1'b1, 1'b0, 160'd1, 160'd0);
      checkOutput("t1_lat1", 160'(o_tvalid), 160'd1);
      checkOutput("t1_first", o_tdata, 160'd1);
      applyStimulus(1'b1, 1'b0, 160'd2, 160'd0);
      applyStimulus(1'b1, 1'b0, 160'd3, 160'd0);
      applyStimulus(1'b0, 1'b0, 160'd4, 160'd0);
      idle(4);
      checkOutput("t1_count", 160'(mon_q.size()), 160'd4);
      for (int i = 0; i < 4; i++) begin
         checkWord("t1_w", i, 160'(i + 1), 1'b0, (i == 3));
      end
      mon_q.delete();

      // Single-word pong burst
      applyStimulus(1'b0, 1'b1, 160'd0, 160'd0);
      applyStimulus(1'b0, 1'b0, 160'd0, 160'hAB);
      idle(3);
      checkOutput("t2_count", 160'(mon_q.size()), 160'd1);
      checkWord("t2_w", 0, 160'hAB, 1'b1, 1'b1);
      mon_q.delete();

      // Backpressure: 20 words into a 16-deep FIFO
      i_tready = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         applyStimulus((i < 20), 1'b0, 160'(i), 160'd0);
         if (i == 11) checkOutput("t3_afull_11", 160'(o_afull), 160'd0);
         if (i == 12) checkOutput("t3_afull_12", 160'(o_afull), 160'd1);
         if (i == 16) checkOutput("t3_ovf_16", 160'(o_overflow), 160'd0);
         if (i == 17) checkOutput("t3_ovf_17", 160'(o_overflow), 160'd1);
      end
      idle(2);
      checkOutput("t3_hold_valid", 160'(o_tvalid), 160'd1);
      checkOutput("t3_hold_data", o_tdata, 160'd1);
      checkOutput("t3_hold_last", 160'(o_tlast), 160'd0);
      i_tready = 1'b1;
      idle(20);
      checkOutput("t3_count", 160'(mon_q.size()), 160'd16);
      for (int i = 0; i < 16; i++) begin
         checkWord("t3_w", i, 160'(i + 1), 1'b0, 1'b0);
      end
      checkOutput("t3_afull_drained", 160'(o_afull), 160'd0);
      checkOutput("t3_ovf_sticky", 160'(o_overflow), 160'd1);
      mon_q.delete();

      // Ping and pong requested together: ping wins, error flag sticks
      checkOutput("t4_sel_err_pre", 160'(o_sel_err), 160'd0);
      for (int k = 0; k <= 3; k++) begin
         applyStimulus((k < 3), (k < 3), 160'(32'h100 + k), 160'(32'h200 + k));
      end
      idle(3);
      checkOutput("t4_sel_err", 160'(o_sel_err), 160'd1);
      checkOutput("t4_count", 160'(mon_q.size()), 160'd3);
      for (int k = 0; k < 3; k++) begin
         checkWord("t4_w", k, 160'(32'h101 + k), 1'b0, (k == 2));
      end
      idle(5);
      checkOutput("t4_sel_err_hold", 160'(o_sel_err), 160'd1);
      mon_q.delete();

      // Reset after 5 of 10 words; the remaining burst must be ignored
      i_tready = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, 160'(i), 160'd0);
      end
      checkOutput("t5_pre_valid", 160'(o_tvalid), 160'd1);
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_valid", 160'(o_tvalid), 160'd0);
      checkOutput("t5_rst_tdata", o_tdata, 160'd0);
      checkOutput("t5_rst_ovf", 160'(o_overflow), 160'd0);
      checkOutput("t5_rst_sel_err", 160'(o_sel_err), 160'd0);
      checkOutput("t5_rst_afull", 160'(o_afull), 160'd0);
      applyStimulus(1'b1, 1'b0, 160'd6, 160'd0);
      applyStimulus(1'b1, 1'b0, 160'd7, 160'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 160'd8, 160'd0);
      applyStimulus(1'b1, 1'b0, 160'd9, 160'd0);
      applyStimulus(1'b1, 1'b0, 160'd10, 160'd0);
      checkOutput("t5_post_valid", 160'(o_tvalid), 160'd0);
      i_tready = 1'b1;
      idle(4);
      checkOutput("t5_idle_valid", 160'(o_tvalid), 160'd0);
      checkOutput("t5_idle_count", 160'(mon_q.size()), 160'd0);
      applyStimulus(1'b0, 1'b1, 160'd0, 160'd0);
      applyStimulus(1'b0, 1'b1, 160'd0, 160'h55);
      applyStimulus(1'b0, 1'b0, 160'd0, 160'h66);
      idle(3);
      checkOutput("t5_new_count", 160'(mon_q.size()), 160'd2);
      checkWord("t5_w0", 0, 160'h55, 1'b1, 1'b0);
      checkWord("t5_w1", 1, 160'h66, 1'b1, 1'b1);
      mon_q.delete();

`ifdef HARQ_SEND_PARITY_EN
      // A single 1 in lane 0 gives odd parity only in lane 0
      i_tready = 1'b0;
      applyStimulus(1'b0, 1'b1, 160'd0, 160'd0);
      applyStimulus(1'b0, 1'b0, 160'd0, 160'h1);
      checkOutput("t6_tdata", o_tdata, 160'h1);
      checkOutput("t6_parity", 160'(o_parity), 160'(10'b0000000001));
      i_tready = 1'b1;
      idle(3);
      mon_q.delete();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/harq_send_packer.md
HARQ_SEND_PACKER -- requirements
Module: harq_send_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: number of 160-bit entries in the output FIFO (power of 2, 4..64).
REQ-002 SHALL have parameter AFULL_LVL, default 12: occupancy at or above which o_afull is asserted.
REQ-003 SHALL have ports: i_core_clk  in  1  single clock for all logic.
REQ-004 SHALL have ports: i_rx_rst  in  1  asynchronous reset, active-high.
REQ-005 SHALL have ports: i_ping_busy  in  1  the send FSM is issuing ping-buffer read addresses.
REQ-006 SHALL have ports: i_pong_busy  in  1  the send FSM is issuing pong-buffer read addresses.
REQ-007 SHALL have ports: i_ping_rd_data  in  160  ping SRAM read data, valid 1 cycle after the address.
REQ-008 SHALL have ports: i_pong_rd_data  in  160  pong SRAM read data, valid 1 cycle after the address.
REQ-009 SHALL have ports: o_tdata  out  160  output word.
REQ-010 SHALL have ports: o_tvalid  out  1  o_tdata is valid.
REQ-011 SHALL have ports: i_tready  in  1  the consumer accepts a word.
REQ-012 SHALL have ports: o_tlast  out  1  last word of a burst.
REQ-013 SHALL have ports: o_tsrc  out  1  word source (0 = ping, 1 = pong).
REQ-014 SHALL have ports: o_afull  out  1  FIFO occupancy >= AFULL_LVL.
REQ-015 SHALL have ports: o_overflow  out  1  sticky flag, a word was dropped.
REQ-016 SHALL have ports: o_sel_err  out  1  sticky flag, ping busy and pong busy were high together.
REQ-017 SHALL have ports: o_parity  out  10  per-16-bit-lane even parity of o_tdata (present only with the macro).

Function
REQ-018 SHALL register busy_d = {i_ping_busy, i_pong_busy} every cycle to align with the 1-cycle SRAM read latency.
REQ-019 SHALL capture a word in cycle N+1 when ping or pong was busy in cycle N.
REQ-020 SHALL take the captured word from i_ping_rd_data when ping_busy_d=1, otherwise from i_pong_rd_data.
REQ-021 SHALL tag each captured word with src (0 = ping, 1 = pong).
REQ-022 SHALL set last=1 on a captured word when the selected busy_d=1 and the same busy input is 0 in the capture cycle.
REQ-023 SHALL, when ping and pong are busy in the same cycle, select ping and set o_sel_err, which holds until reset.
REQ-024 SHALL write each captured word, tagged with src and last, into a FIFO of FIFO_DEPTH entries.
REQ-025 SHALL, when the FIFO is full, drop the captured word without corrupting any stored entry and set o_overflow, which holds until reset.
REQ-026 SHALL accept a write while full when a pop occurs in the same cycle (no drop, no overflow).
REQ-027 SHALL drive o_tvalid as FIFO not empty, with o_tdata, o_tlast and o_tsrc taken from the head entry.
REQ-028 SHALL pop the head entry only when o_tvalid=1 and i_tready=1.
REQ-029 SHALL keep o_tdata, o_tlast and o_tsrc stable while o_tvalid=1 and i_tready=0.
REQ-030 SHALL present a word on o_tdata/o_tvalid 1 cycle after capture (output registered from the FIFO, FIFO empty).
REQ-031 SHALL handle push and pop in the same cycle with occupancy unchanged.
REQ-032 SHALL update o_afull combinationally from registered occupancy.
REQ-033 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with one extra bit used to tell full from empty.

Reset
REQ-034 SHALL, while i_rx_rst=1, immediately force o_tvalid=0, o_tlast=0, o_tsrc=0, o_tdata=0, o_afull=0, o_overflow=0, o_sel_err=0, busy_d=0 and FIFO pointers to 0.
REQ-035 SHALL, on reset asserted mid-burst, discard all FIFO contents, with no partial burst output after release.
REQ-036 SHALL, after reset release, ignore a burst already in progress until the busy inputs are seen low for at least 1 cycle.

Configuration
REQ-037 SHALL, with HARQ_SEND_PARITY_EN defined, store 10 parity bits per entry (bit k = XOR of data[16k+15:16k]) and drive them on o_parity, aligned with o_tdata.
REQ-038 SHALL, without HARQ_SEND_PARITY_EN, have no o_parity port and no parity storage.

Verification
REQ-039 SHALL verify a ping burst: ping busy high 4 cycles, data 0x1..0x4, i_tready=1 -> 4 words 0x1..0x4, src=0, o_tlast only on 0x4, first o_tvalid 2 cycles after busy rises.
REQ-040 SHALL verify a pong burst: pong busy high 1 cycle, data 0xAB -> single word 0xAB, src=1, o_tlast=1.
REQ-041 SHALL verify backpressure: i_tready=0, ping burst of 20 words -> 16 stored, o_afull from the 12th word, o_overflow=1; then i_tready=1 -> exactly words 1..16 out, none corrupted.
REQ-042 SHALL verify a simultaneous request: ping and pong busy together for 3 cycles -> ping data taken, o_sel_err=1 until reset.
REQ-043 SHALL verify reset mid-burst: assert i_rx_rst after 5 of 10 words -> o_tvalid=0 at once; after release, no output until a new burst.
REQ-044 SHALL verify parity with HARQ_SEND_PARITY_EN: word 0x0001 in lane 0, others 0 -> o_parity=10'b0000000001.
